sad_search_ctrl: RTL

//  Sequencer for the SAD datapath: exhaustive 4x4 block-match of one window against a frame.

---
 rtl/sad_search_ctrl_pkg.sv | 27 ++
 rtl/sad_search_ctrl_if.sv | 36 +++
 rtl/sad_search_ctrl_min_tracker.sv | 36 +++
 rtl/sad_search_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sad_search_ctrl_pkg.sv
// Shared encodings for the SAD block-match sequencer.
package sad_search_ctrl_pkg;

    // The column advance is folded into the last COL_RUN cycle. Because of
    // that, NEXT_COL never has a cycle of its own and has no encoding here.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD_WIN = 2'd1,
        S_COL_RUN  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // Tag that travels with each read into its data cycle.
    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_WIN     = 2'd1,
        TAG_FRM     = 2'd2,
        TAG_FRM_CMP = 2'd3
    } tag_t;

    localparam logic [31:0] SAD_MAX = 32'hFFFF_FFFF;

    function automatic logic is_frame_tag(input tag_t t);
        return (t == TAG_FRM) || (t == TAG_FRM_CMP);
    endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Bundle of the CSR side, the SAD memory port and the SAD unit controls.
interface sad_search_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] frm_base;
    logic [ADDR_W-1:0] frm_stride;
    logic [DIM_W-1:0]  frm_w;
    logic [DIM_W-1:0]  frm_h;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              window_shift;
    logic              frame_shift;
    logic [31:0]       sad_value;
    logic              busy;
    logic              done;
    logic [31:0]       best_sad;
    logic [DIM_W-1:0]  best_x;
    logic [DIM_W-1:0]  best_y;

    // Core / SAD unit side
    modport master (
        output start, win_base, frm_base, frm_stride, frm_w, frm_h, sad_value,
        input  mem_rd, mem_addr, window_shift, frame_shift,
               busy, done, best_sad, best_x, best_y
    );

    // Sequencer side
    modport slave (
        input  start, win_base, frm_base, frm_stride, frm_w, frm_h, sad_value,
        output mem_rd, mem_addr, window_shift, frame_shift,
               busy, done, best_sad, best_x, best_y
    );
endinterface

// File: rtl/sad_search_ctrl_min_tracker.sv
// Running minimum of SAD values with the coordinates of the first minimum.
module sad_min_tracker
    import sad_search_ctrl_pkg::*;
#(
    parameter int DIM_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [31:0]      sad,
    input  logic [DIM_W-1:0] x,
    input  logic [DIM_W-1:0] y,
    output logic [31:0]      best_sad,
    output logic [DIM_W-1:0] best_x,
    output logic [DIM_W-1:0] best_y
);

    // Strictly-smaller update, so on a tie the earlier candidate stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad <= SAD_MAX;
            best_x   <= '0;
            best_y   <= '0;
        end else if (clear) begin
            best_sad <= SAD_MAX;
            best_x   <= '0;
            best_y   <= '0;
        end else if (valid && (sad < best_sad)) begin
            best_sad <= sad;
            best_x   <= x;
            best_y   <= y;
        end
    end

endmodule

// File: rtl/sad_search_ctrl.sv
// Exhaustive 4x4 block-match sequencer: reads the window, then scans the
// frame column-major and feeds the SAD unit, keeping the best candidate.
module sad_search_ctrl
    import sad_search_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 10
) (
    input logic               clk,
    input logic               rst_n,
    sad_search_ctrl_if.slave  bus
);

    state_t            state, next_state;
    tag_t              tag_iss, tag_q;
    logic              rd, accept;
    logic              last_row, last_col;
    logic [ADDR_W-1:0] addr, col_base, stride_q;
    logic [DIM_W-1:0]  w_q, h_q, x_cnt, y_cnt;
    logic [DIM_W-1:0]  cand_x_q, cand_y_q;
    logic              done_q;

    assign last_row = (y_cnt == h_q - DIM_W'(1));
    assign last_col = (x_cnt == w_q - DIM_W'(4));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next state and read issue. Row 3 onward of each column completes a
    // candidate, so those reads carry the compare tag.
    always_comb begin
        next_state = state;
        rd         = 1'b0;
        tag_iss    = TAG_NONE;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if ((bus.frm_w < DIM_W'(4)) || (bus.frm_h < DIM_W'(4)))
                        next_state = S_DONE;
                    else
                        next_state = S_LOAD_WIN;
                end
            end
            S_LOAD_WIN: begin
                rd      = 1'b1;
                tag_iss = TAG_WIN;
                if (y_cnt == DIM_W'(3)) next_state = S_COL_RUN;
            end
            S_COL_RUN: begin
                rd      = 1'b1;
                tag_iss = (y_cnt >= DIM_W'(3)) ? TAG_FRM_CMP : TAG_FRM;
                if (last_row && last_col) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Config latch, row/column counters and incremental address generation.
    // At the end of a column the next column's base goes straight onto the
    // address, so row 0 of x+1 follows the last row of x with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            col_base <= '0;
            stride_q <= '0;
            w_q      <= '0;
            h_q      <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else if (accept) begin
            addr     <= bus.win_base;
            col_base <= bus.frm_base;
            stride_q <= bus.frm_stride;
            w_q      <= bus.frm_w;
            h_q      <= bus.frm_h;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else if (state == S_LOAD_WIN) begin
            if (y_cnt == DIM_W'(3)) begin
                y_cnt <= '0;
                addr  <= col_base;
            end else begin
                y_cnt <= y_cnt + DIM_W'(1);
                addr  <= addr + ADDR_W'(4);
            end
        end else if (state == S_COL_RUN) begin
            if (last_row) begin
                y_cnt    <= '0;
                x_cnt    <= x_cnt + DIM_W'(1);
                col_base <= col_base + ADDR_W'(1);
                addr     <= col_base + ADDR_W'(1);
            end else begin
                y_cnt <= y_cnt + DIM_W'(1);
                addr  <= addr + stride_q;
            end
        end
    end

    // Tag pipeline: carries each read's tag and candidate coordinates into
    // the cycle its data is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= TAG_NONE;
            cand_x_q <= '0;
            cand_y_q <= '0;
            done_q   <= 1'b0;
        end else begin
            tag_q    <= tag_iss;
            cand_x_q <= x_cnt;
            cand_y_q <= y_cnt - DIM_W'(3);
            done_q   <= (state == S_DONE);
        end
    end

    sad_min_tracker #(.DIM_W(DIM_W)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .valid    (tag_q == TAG_FRM_CMP),
        .sad      (bus.sad_value),
        .x        (cand_x_q),
        .y        (cand_y_q),
        .best_sad (bus.best_sad),
        .best_x   (bus.best_x),
        .best_y   (bus.best_y)
    );

    assign bus.mem_rd       = rd;
    assign bus.mem_addr     = rd ? addr : '0;
    assign bus.window_shift = (tag_q == TAG_WIN);
    assign bus.frame_shift  = is_frame_tag(tag_q);
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = done_q;

endmodule
